controlador_elevador: RTL and testbench
=======================================

// Module: controlador_elevador
// PURPOSE
//  Elevator car scheduler: latches floor calls from N_FLOORS call buttons and shares the single car between them.
//  Uses SCAN ordering: serve calls ahead in the current direction, reverse only when none remain.
//  Sequences motor up/down and door; tracks logical floor position. Sits between button/sync logic and motor/door drivers.
// PARAMETERS
//  N_FLOORS     4  number of floors served (>=2)
//  FLOOR_BITS   2  width of floor index, must satisfy 2**FLOOR_BITS >= N_FLOORS
//  MOVE_CYCLES  4  clk cycles to travel one floor (>=2)
//  DOOR_CYCLES  3  clk cycles door stays open (>=1)
// PORTS
//  clk            in   1           system clock, rising edge
//  reset          in   1           asynchronous, active-low (0 = reset)
//  call_req       in   N_FLOORS    call button per floor, level, synchronous to clk
//  door_obstruct  in   1           1 = doorway blocked; holds door open
//  floor          out  FLOOR_BITS  current logical floor
//  motor_up       out  1           1 while car travels up
//  motor_down     out  1           1 while car travels down
//  door_open      out  1           1 while door is open
//  pending        out  N_FLOORS    registered outstanding calls
//  busy           out  1           1 whenever state != IDLE
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, floor=0, dir=UP, pending=0, timer=0; all outputs 0. Reset mid-move/mid-door aborts immediately.
//  Call latch: at each edge, pending[i] <= pending[i] | call_req[i], except clear rule. Clear wins over set at the same edge.
//  Clear rule: pending[f] cleared on the edge entering DOOR_OPEN at floor f.
//   A call at floor f while DOOR_OPEN at f restarts the door timer and is not latched.
//  States (encoding in shared header): IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
//  IDLE decision uses registered pending only (1-cycle call-to-action latency):
//   pending[floor]                      -> DOOR_OPEN (clear it)
//   else any above & (dir=UP | none below) -> MOVE_UP, dir=UP
//   else any below                      -> MOVE_DOWN, dir=DOWN
//   else stay IDLE.
//  MOVE_x: timer counts 0..MOVE_CYCLES-1. On the edge with timer=MOVE_CYCLES-1: floor+/-1, timer=0.
//   If pending[new floor] -> DOOR_OPEN; else continue in same state.
//   The car never goes beyond floor 0 or N_FLOORS-1; reaching an end with no call there is illegal (assertion).
//  DOOR_OPEN: door_open=1; timer counts 0..DOOR_CYCLES-1; door_obstruct=1 or a same-floor call forces timer=0.
//   On expiry -> IDLE; the IDLE decision runs the next cycle.
//  Output timing: motor_up=1 iff state=MOVE_UP; motor_down=1 iff state=MOVE_DOWN; door_open=1 iff state=DOOR_OPEN.
//   All outputs are registered or decoded from registered state; never combinational from inputs.
//  Exclusivity: motor_up, motor_down and door_open are mutually exclusive in every cycle.
//  Arithmetic: floor stays in range; timer width is clog2(max(MOVE_CYCLES,DOOR_CYCLES)); no wrap permitted.
//  Simultaneous calls above and below while IDLE: current dir wins (SCAN); with dir=UP, up wins.
// STRUCTURE
//  Shared header elevador_defs.vh: state encodings (2 bits), DIR_UP/DIR_DOWN constants.
//  One sub-module, contador_ciclos: loadable down/up cycle timer with clear and terminal-count output.
//   Instantiated once and shared between the move and door phases.
//  Remaining logic (pending register, next-state, floor counter) stays in this module.
// TESTING (defaults: 4 floors, MOVE_CYCLES=4, DOOR_CYCLES=3)
//  1 Reset then idle 10 cycles -> floor=0, pending=0, all outputs 0, busy=0.
//  2 Idle at 0, call_req=0100 pulse at edge 0 -> pending[2]=1 at edge 0; MOVE_UP from edge 1; floor=1 at edge 5;
//    floor=2 + DOOR_OPEN + pending[2]=0 at edge 9; IDLE at edge 12.
//  3 At floor 2 moving down toward 0 with call at 3 latched mid-move -> stops at 0 first, then reverses to 3.
//  4 Idle at floor 1, calls 0 and 3 latched same edge, dir=UP -> serves 3 then 0.
//  5 DOOR_OPEN, door_obstruct=1 for 10 cycles -> door stays open; closes 3 cycles after release.
//  6 reset=0 asynchronously during MOVE_DOWN (mid-timer) -> outputs 0 immediately, floor=0, pending=0.

Source files
------------

// File: rtl/controlador_elevador_pkg.sv
// Shared definitions for the elevator scheduler: state encoding, travel
// direction constants and a small constant helper used to size the timer.
package controlador_elevador_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_MOVE_UP   = 2'd1,
      ST_MOVE_DOWN = 2'd2,
      ST_DOOR_OPEN = 2'd3
   } estado_e;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/controlador_elevador_contador_ciclos.sv
// Cycle timer shared by the travel and door phases. Counts 0..last_i,
// flags the terminal count and wraps back to 0 on the following enabled edge.
module contador_ciclos #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en_i,
   input  logic         clr_i,
   input  logic [W-1:0] last_i,
   output logic         tc_o
);

   logic [W-1:0] cnt_q;

   assign tc_o = (cnt_q == last_i);

   // count register: clear has priority, wrap to 0 after the terminal count
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        cnt_q <= '0;
      else if (clr_i)    cnt_q <= '0;
      else if (en_i)     cnt_q <= tc_o ? '0 : cnt_q + W'(1);
   end

endmodule

// File: rtl/controlador_elevador.sv
// Elevator car scheduler: latches floor calls and moves a single car using
// SCAN ordering (keep going while calls remain ahead, reverse otherwise).
// All outputs are decoded from registered state only.
module controlador_elevador
   import controlador_elevador_pkg::*;
#(
   parameter int N_FLOORS    = 4,
   parameter int FLOOR_BITS  = 2,
   parameter int MOVE_CYCLES = 4,
   parameter int DOOR_CYCLES = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_FLOORS-1:0]   call_req,
   input  logic                  door_obstruct,
   output logic [FLOOR_BITS-1:0] floor,
   output logic                  motor_up,
   output logic                  motor_down,
   output logic                  door_open,
   output logic [N_FLOORS-1:0]   pending,
   output logic                  busy
);

   localparam int TW = $clog2(max_int(MOVE_CYCLES, DOOR_CYCLES));
   localparam logic [TW-1:0]         MOVE_LAST = TW'(MOVE_CYCLES - 1);
   localparam logic [TW-1:0]         DOOR_LAST = TW'(DOOR_CYCLES - 1);
   localparam logic [FLOOR_BITS-1:0] TOP_FLOOR = FLOOR_BITS'(N_FLOORS - 1);

   estado_e                 state_q, state_d;
   logic [FLOOR_BITS-1:0]   floor_q, floor_d;
   logic                    dir_q, dir_d;
   logic [N_FLOORS-1:0]     pending_q, pending_d;
   logic [N_FLOORS-1:0]     set_mask, clr_mask;
   logic                    any_above, any_below;
   logic                    tmr_en, tmr_clr, tmr_hold, tmr_tc;
   logic [TW-1:0]           tmr_last;

   contador_ciclos #(.W(TW)) u_timer (
      .clk    (clk),
      .reset  (reset),
      .en_i   (tmr_en),
      .clr_i  (tmr_clr),
      .last_i (tmr_last),
      .tc_o   (tmr_tc)
   );

   // outstanding calls strictly above / below the car
   always_comb begin
      any_above = 1'b0;
      any_below = 1'b0;
      for (int i = 0; i < N_FLOORS; i++) begin
         if (pending_q[i] && (i > int'(floor_q))) any_above = 1'b1;
         if (pending_q[i] && (i < int'(floor_q))) any_below = 1'b1;
      end
   end

   // next-state, floor, direction, call latch and timer control
   always_comb begin
      state_d  = state_q;
      floor_d  = floor_q;
      dir_d    = dir_q;
      clr_mask = '0;
      set_mask = call_req;
      tmr_hold = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pending_q[floor_q]) begin
               state_d           = ST_DOOR_OPEN;
               clr_mask[floor_q] = 1'b1;
            end else if (any_above && (dir_q == DIR_UP || !any_below)) begin
               state_d = ST_MOVE_UP;
               dir_d   = DIR_UP;
            end else if (any_below) begin
               state_d = ST_MOVE_DOWN;
               dir_d   = DIR_DOWN;
            end
         end
         ST_MOVE_UP: begin
            if (tmr_tc) begin
               floor_d = floor_q + FLOOR_BITS'(1);
               if (pending_q[floor_d]) begin
                  state_d           = ST_DOOR_OPEN;
                  clr_mask[floor_d] = 1'b1;
               end
            end
         end
         ST_MOVE_DOWN: begin
            if (tmr_tc) begin
               floor_d = floor_q - FLOOR_BITS'(1);
               if (pending_q[floor_d]) begin
                  state_d           = ST_DOOR_OPEN;
                  clr_mask[floor_d] = 1'b1;
               end
            end
         end
         ST_DOOR_OPEN: begin
            // a call at the open floor only re-arms the door, it is never latched
            set_mask[floor_q] = 1'b0;
            tmr_hold = door_obstruct | call_req[floor_q];
            if (!tmr_hold && tmr_tc) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      pending_d = (pending_q | set_mask) & ~clr_mask;
      tmr_last  = (state_q == ST_DOOR_OPEN) ? DOOR_LAST : MOVE_LAST;
      tmr_en    = (state_q != ST_IDLE);
      tmr_clr   = (state_q == ST_IDLE) | (state_d != state_q) | tmr_hold;
   end

   // state, position, direction and call registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         floor_q   <= '0;
         dir_q     <= DIR_UP;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         floor_q   <= floor_d;
         dir_q     <= dir_d;
         pending_q <= pending_d;
      end
   end

   assign floor      = floor_q;
   assign pending    = pending_q;
   assign motor_up   = (state_q == ST_MOVE_UP);
   assign motor_down = (state_q == ST_MOVE_DOWN);
   assign door_open  = (state_q == ST_DOOR_OPEN);
   assign busy       = (state_q != ST_IDLE);

   // the car must always stop at an end floor, never try to travel past it
   a_no_overrun_up: assert property (@(posedge clk) disable iff (!reset)
      (state_q == ST_MOVE_UP) |-> (floor_q != TOP_FLOOR));
   a_no_overrun_dn: assert property (@(posedge clk) disable iff (!reset)
      (state_q == ST_MOVE_DOWN) |-> (floor_q != '0));

endmodule

// File: tb/tb_controlador_elevador.sv
// Bench for the elevator scheduler: directed scenarios plus random calls,
// every cycle compared against a behavioural model built from countdowns.
module tb_controlador_elevador;

   localparam int N    = 4;
   localparam int FB   = 2;
   localparam int MOVE = 4;
   localparam int DOOR = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  call_req;
   logic          door_obstruct;
   logic [FB-1:0] floor;
   logic          motor_up, motor_down, door_open, busy;
   logic [N-1:0]  pending;

   int n_chk = 0;
   int n_err = 0;

   // reference model: position, travel sign (+1/-1/0), heading, countdowns
   int           m_pos, m_trav, m_head, m_tl, m_dl;
   logic [N-1:0] m_pend;

   controlador_elevador #(
      .N_FLOORS(N), .FLOOR_BITS(FB), .MOVE_CYCLES(MOVE), .DOOR_CYCLES(DOOR)
   ) dut (
      .clk(clk), .reset(reset), .call_req(call_req), .door_obstruct(door_obstruct),
      .floor(floor), .motor_up(motor_up), .motor_down(motor_down),
      .door_open(door_open), .pending(pending), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pos = 0; m_trav = 0; m_head = 1; m_tl = 0; m_dl = 0; m_pend = '0;
   endtask

   task automatic model_step(input logic [N-1:0] c, input logic ob);
      logic [N-1:0] setm, clrm;
      bit above, below;
      setm = c; clrm = '0;
      if (m_dl > 0) begin
         setm[m_pos] = 1'b0;
         if (ob || c[m_pos]) m_dl = DOOR;
         else m_dl--;
      end else if (m_trav != 0) begin
         m_tl--;
         if (m_tl == 0) begin
            m_pos += m_trav;
            m_tl = MOVE;
            if (m_pend[m_pos]) begin
               m_trav = 0; m_dl = DOOR; clrm[m_pos] = 1'b1;
            end
         end
      end else begin
         above = 0; below = 0;
         for (int i = 0; i < N; i++) begin
            if (m_pend[i] && i > m_pos) above = 1;
            if (m_pend[i] && i < m_pos) below = 1;
         end
         if (m_pend[m_pos]) begin
            m_dl = DOOR; clrm[m_pos] = 1'b1;
         end else if (above && (m_head > 0 || !below)) begin
            m_trav = 1; m_head = 1; m_tl = MOVE;
         end else if (below) begin
            m_trav = -1; m_head = -1; m_tl = MOVE;
         end
      end
      m_pend = (m_pend | setm) & ~clrm;
   endtask

   task automatic compare_all();
      check("floor",      floor,      m_pos);
      check("motor_up",   motor_up,   m_trav == 1);
      check("motor_down", motor_down, m_trav == -1);
      check("door_open",  door_open,  m_dl > 0);
      check("pending",    pending,    m_pend);
      check("busy",       busy,       (m_trav != 0) || (m_dl > 0));
      check("exclusive",  (motor_up + motor_down + door_open) <= 1, 1);
   endtask

   // one clock: drive at negedge, model at posedge, compare at next negedge
   task automatic cyc(input logic [N-1:0] c, input logic ob);
      call_req = c; door_obstruct = ob;
      @(posedge clk);
      model_step(c, ob);
      @(negedge clk);
      compare_all();
   endtask

   task automatic wait_door(input string tag, output int fl);
      int n = 0;
      while (!door_open && n < 60) begin cyc('0, 1'b0); n++; end
      check({tag, "_timeout"}, n < 60, 1);
      fl = floor;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 60) begin cyc('0, 1'b0); n++; end
      check({tag, "_timeout"}, n < 60, 1);
   endtask

   initial begin
      int fl, n;
      logic [N-1:0] rc;
      reset = 1'b0; call_req = '0; door_obstruct = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_floor", floor, 0);
      check("rst_busy",  busy, 0);
      check("rst_outs",  {motor_up, motor_down, door_open, pending}, 0);
      reset = 1'b1;

      // idle for 10 cycles
      repeat (10) cyc('0, 1'b0);
      check("t1_floor", floor, 0);
      check("t1_busy",  busy, 0);

      // single call to floor 2 from floor 0, edge-exact timing
      cyc(4'b0100, 1'b0);                     // edge 0
      check("t2_latch", pending, 4'b0100);
      cyc('0, 1'b0);                          // edge 1
      check("t2_up", motor_up, 1);
      repeat (4) cyc('0, 1'b0);               // edges 2..5
      check("t2_floor1", floor, 1);
      repeat (4) cyc('0, 1'b0);               // edges 6..9
      check("t2_floor2", floor, 2);
      check("t2_door",   door_open, 1);
      check("t2_clear",  pending, 0);
      repeat (3) cyc('0, 1'b0);               // edges 10..12
      check("t2_idle", busy, 0);

      // moving down toward 0, call at 3 arrives mid-move
      cyc(4'b0001, 1'b0);
      repeat (3) cyc('0, 1'b0);
      cyc(4'b1000, 1'b0);
      wait_door("t3a", fl);
      check("t3_first", fl, 0);
      wait_idle("t3b");
      wait_door("t3c", fl);
      check("t3_second", fl, 3);
      wait_idle("t3d");

      // get to floor 1 heading up, then calls at 0 and 3 on the same edge
      cyc(4'b0001, 1'b0);
      wait_door("t4a", fl); wait_idle("t4b");
      cyc(4'b0010, 1'b0);
      wait_door("t4c", fl); wait_idle("t4d");
      check("t4_at1", floor, 1);
      cyc(4'b1001, 1'b0);
      wait_door("t4e", fl);
      check("t4_first", fl, 3);
      wait_idle("t4f");
      wait_door("t4g", fl);
      check("t4_second", fl, 0);
      wait_idle("t4h");

      // obstructed door held 10 cycles, closes 3 cycles after release
      cyc(4'b0001, 1'b0);
      cyc('0, 1'b0);
      check("t5_open", door_open, 1);
      repeat (10) begin
         cyc('0, 1'b1);
         check("t5_held", door_open, 1);
      end
      n = 0;
      do begin cyc('0, 1'b0); n++; end while (door_open && n < 8);
      check("t5_close", n, 3);

      // async reset in the middle of a downward move
      cyc(4'b0100, 1'b0);
      wait_door("t6a", fl); wait_idle("t6b");
      cyc(4'b0001, 1'b0);
      cyc('0, 1'b0);
      cyc('0, 1'b0);
      cyc(4'b1000, 1'b0);
      check("t6_moving", motor_down, 1);
      call_req = '0;
      #2 reset = 1'b0;
      #1;
      check("t6_floor", floor, 0);
      check("t6_pend",  pending, 0);
      check("t6_outs",  {motor_up, motor_down, door_open, busy}, 0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      compare_all();

      // random traffic
      repeat (700) begin
         rc = '0;
         for (int i = 0; i < N; i++) rc[i] = ($urandom_range(0, 15) == 0);
         cyc(rc, $urandom_range(0, 7) == 0);
      end
      repeat (60) cyc('0, 1'b0);
      check("drain_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
